// File: rtl/fabric_bram_dp.sv
// -----------------------------------------------------------------------------
// fabric_bram_dp
//   Dual-port, aspect-ratio-configurable block RAM. Both ports share one
//   DEPTH x WORD_W array. Each port picks its own access width
//   (WORD_W >> conf), its own output registering and its own write mode.
//   Sub-word data is right-justified on the fabric data buses.
//
// Parameters
//   WORD_W  native word width (power of two, >= 2)
//   DEPTH   native word count (power of two)
//   CONF_W  width-select bits (must hold log2(WORD_W))
//   WA_W    word-address bits (derived)
//   ADDR_W  port address width = WA_W + log2(WORD_W) (derived)
//
// Ports (x = a | b, identical behaviour per port)
//   clk             single clock, rising edge
//   rst             synchronous active-high reset of the read pipeline
//   csb_x           chip select, active low
//   web_x           write enable, active low
//   addr_x          word address in low WA_W bits, lane index in top conf bits
//   conf_x          access width select, width = WORD_W >> conf
//   wmode_x         00 read-first, 01 write-first, 1x no-change
//   out_reg_x       0 = stage-1 on output, 1 = stage-2 on output
//   d_fabric_in_x   right-justified write data
//   d_fabric_out_x  right-justified read data, upper bits zero
//   busy            clear sweep in progress
//
// Optional feature: define FABRIC_BRAM_CLEAR_EN to zero the whole array
// after every reset. Ports are locked out while the sweep runs.
// -----------------------------------------------------------------------------
module fabric_bram_dp #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 512,
    parameter int CONF_W = 3,
    parameter int WA_W   = $clog2(DEPTH),
    parameter int ADDR_W = WA_W + $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csb_a,
    input  logic              web_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [CONF_W-1:0] conf_a,
    input  logic [1:0]        wmode_a,
    input  logic              out_reg_a,
    input  logic [WORD_W-1:0] d_fabric_in_a,
    output logic [WORD_W-1:0] d_fabric_out_a,
    input  logic              csb_b,
    input  logic              web_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [CONF_W-1:0] conf_b,
    input  logic [1:0]        wmode_b,
    input  logic              out_reg_b,
    input  logic [WORD_W-1:0] d_fabric_in_b,
    output logic [WORD_W-1:0] d_fabric_out_b,
    output logic              busy
);

    localparam int LW = $clog2(WORD_W);

    // Access widths narrower than one bit do not exist; such accesses are dropped.
    function automatic logic conf_ok(input logic [CONF_W-1:0] conf);
        return (int'(conf) <= LW);
    endfunction

    // Right-justified mask of the lane width; all ones when conf = 0.
    function automatic logic [WORD_W-1:0] low_mask(input logic [CONF_W-1:0] conf);
        int w;
        w = WORD_W >> conf;
        return ~({WORD_W{1'b1}} << w);
    endfunction

    // Bit offset of the addressed lane: lane index from the top conf address
    // bits, scaled by the lane width.
    function automatic int lane_off(input logic [ADDR_W-1:0] addr,
                                    input logic [CONF_W-1:0] conf);
        int k;
        if ((conf == {CONF_W{1'b0}}) || !conf_ok(conf)) begin
            k = 32'sd0;
        end else begin
            k = int'(addr >> (ADDR_W - int'(conf)));
        end
        if (conf_ok(conf)) begin
            return k << (LW - int'(conf));
        end else begin
            return 32'sd0;
        end
    endfunction

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Port signals gathered into arrays so both ports share one description.
    logic              csb_s      [2];
    logic              web_s      [2];
    logic [ADDR_W-1:0] addr_s     [2];
    logic [CONF_W-1:0] conf_s     [2];
    logic [1:0]        wmode_s    [2];
    logic [WORD_W-1:0] din_s      [2];
    logic [WA_W-1:0]   wa_s       [2];
    logic              ok_s       [2];
    logic [WORD_W-1:0] lmask_s    [2];
    int                off_s      [2];
    logic [WORD_W-1:0] wmask_s    [2];
    logic [WORD_W-1:0] old_word_s [2];
    logic [WORD_W-1:0] old_lane_s [2];
    logic [WORD_W-1:0] new_lane_s [2];
    logic [WORD_W-1:0] wdata_s    [2];
    logic              acc_s      [2];
    logic              wr_s       [2];
    logic [WORD_W-1:0] s1_r       [2];
    logic [WORD_W-1:0] s2_r       [2];
    logic              same_s;
    logic [WORD_W-1:0] merged_s;
    logic              busy_s;
    logic              acc_en_s;
    logic              clr_we_s;
    logic [WA_W-1:0]   clr_addr_s;

    assign csb_s[0]   = csb_a;          assign csb_s[1]   = csb_b;
    assign web_s[0]   = web_a;          assign web_s[1]   = web_b;
    assign addr_s[0]  = addr_a;         assign addr_s[1]  = addr_b;
    assign conf_s[0]  = conf_a;         assign conf_s[1]  = conf_b;
    assign wmode_s[0] = wmode_a;        assign wmode_s[1] = wmode_b;
    assign din_s[0]   = d_fabric_in_a;  assign din_s[1]   = d_fabric_in_b;

    assign d_fabric_out_a = out_reg_a ? s2_r[0] : s1_r[0];
    assign d_fabric_out_b = out_reg_b ? s2_r[1] : s1_r[1];

    assign acc_en_s = !rst && !busy_s;
    assign busy     = busy_s;

`ifdef FABRIC_BRAM_CLEAR_EN
    typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;
    clr_state_t      clr_state_r;
    logic [WA_W-1:0] clr_cnt_r;
    logic            busy_r;

    assign busy_s     = busy_r;
    assign clr_we_s   = (clr_state_r == ST_CLEAR) && !rst;
    assign clr_addr_s = clr_cnt_r;

    // Clear sequencer: every reset restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_state_r <= ST_CLEAR;
            clr_cnt_r   <= {WA_W{1'b0}};
            busy_r      <= 1'b1;
        end else begin
            case (clr_state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                end
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + WA_W'(1);
                    if (clr_cnt_r == WA_W'(DEPTH - 1)) begin
                        clr_state_r <= ST_IDLE;
                        busy_r      <= 1'b0;
                    end else begin
                        busy_r      <= 1'b1;
                    end
                end
                default: begin
                    clr_state_r <= ST_IDLE;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end
`else
    assign busy_s     = 1'b0;
    assign clr_we_s   = 1'b0;
    assign clr_addr_s = {WA_W{1'b0}};
`endif

    // Per-port lane decode, old/new lane values and masked write word.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wa_s[p]       = addr_s[p][WA_W-1:0];
            ok_s[p]       = conf_ok(conf_s[p]);
            lmask_s[p]    = low_mask(conf_s[p]);
            off_s[p]      = lane_off(addr_s[p], conf_s[p]);
            wmask_s[p]    = lmask_s[p] << off_s[p];
            old_word_s[p] = mem_r[wa_s[p]];
            old_lane_s[p] = (old_word_s[p] >> off_s[p]) & lmask_s[p];
            new_lane_s[p] = din_s[p] & lmask_s[p];
            wdata_s[p]    = (old_word_s[p] & ~wmask_s[p]) | (new_lane_s[p] << off_s[p]);
            acc_s[p]      = !csb_s[p] && acc_en_s;
            wr_s[p]       = acc_s[p] && !web_s[p] && ok_s[p];
        end
    end

    // Same-word collision: both lanes land, port A owns any overlapping bits.
    always_comb begin
        same_s   = wr_s[0] && wr_s[1] && (wa_s[0] == wa_s[1]);
        merged_s = (old_word_s[0] & ~(wmask_s[0] | wmask_s[1]))
                 | ((new_lane_s[0] << off_s[0]) & wmask_s[0])
                 | ((new_lane_s[1] << off_s[1]) & wmask_s[1] & ~wmask_s[0]);
    end

    // Array update: clear sweep, merged collision write, or independent writes.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_addr_s] <= {WORD_W{1'b0}};
        end else if (same_s) begin
            mem_r[wa_s[0]] <= merged_s;
        end else begin
            if (wr_s[0]) mem_r[wa_s[0]] <= wdata_s[0];
            if (wr_s[1]) mem_r[wa_s[1]] <= wdata_s[1];
        end
    end

    // Read pipeline: stage-1 captures per access rules, stage-2 follows stage-1.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                s1_r[p] <= {WORD_W{1'b0}};
                s2_r[p] <= {WORD_W{1'b0}};
            end else begin
                s2_r[p] <= s1_r[p];
                if (acc_s[p]) begin
                    if (!ok_s[p]) begin
                        s1_r[p] <= {WORD_W{1'b0}};
                    end else if (web_s[p]) begin
                        s1_r[p] <= old_lane_s[p];
                    end else begin
                        case (wmode_s[p])
                            2'b00:   s1_r[p] <= old_lane_s[p];
                            2'b01:   s1_r[p] <= new_lane_s[p];
                            default: s1_r[p] <= s1_r[p];
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fabric_bram_dp.sv
// -----------------------------------------------------------------------------
// tb_fabric_bram_dp
//   Directed, table-driven bench for fabric_bram_dp. Each table row drives
//   both ports for one clock edge and lists the expected read data after it.
//   Reset, array retention and the optional clear sweep are hand sequences.
// -----------------------------------------------------------------------------
module tb_fabric_bram_dp;

`ifdef FABRIC_BRAM_CLEAR_EN
    localparam int TB_DEPTH = 16;
`else
    localparam int TB_DEPTH = 512;
`endif
    localparam int ADDR_W = $clog2(TB_DEPTH) + 5;

    logic              clk, rst, busy;
    logic              csb_a, web_a, out_reg_a, csb_b, web_b, out_reg_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [2:0]        conf_a, conf_b;
    logic [1:0]        wmode_a, wmode_b;
    logic [31:0]       din_a, din_b, dout_a, dout_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    fabric_bram_dp #(.WORD_W(32), .DEPTH(TB_DEPTH), .CONF_W(3)) dut (
        .clk(clk), .rst(rst),
        .csb_a(csb_a), .web_a(web_a), .addr_a(addr_a), .conf_a(conf_a),
        .wmode_a(wmode_a), .out_reg_a(out_reg_a),
        .d_fabric_in_a(din_a), .d_fabric_out_a(dout_a),
        .csb_b(csb_b), .web_b(web_b), .addr_b(addr_b), .conf_b(conf_b),
        .wmode_b(wmode_b), .out_reg_b(out_reg_b),
        .d_fabric_in_b(din_b), .d_fabric_out_b(dout_b),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        wr;
        logic [1:0]  wm;
        logic        oreg;
        int          conf;
        int          lane;
        int          word;
        logic [31:0] din;
        logic        chk;
        logic [31:0] exp;
    } op_t;

    typedef struct {
        op_t a;
        op_t b;
    } vec_t;

    vec_t vq[$];

    function automatic op_t rd(int conf, int lane, int word, logic oreg, logic [31:0] exp);
        return '{1'b1, 1'b0, 2'b10, oreg, conf, lane, word, 32'h0, 1'b1, exp};
    endfunction

    function automatic op_t wr(int conf, int lane, int word, logic [31:0] din,
                               logic [1:0] wm, logic chk, logic [31:0] exp);
        return '{1'b1, 1'b1, wm, 1'b0, conf, lane, word, din, chk, exp};
    endfunction

    function automatic op_t nop(logic oreg, logic chk, logic [31:0] exp);
        return '{1'b0, 1'b0, 2'b10, oreg, 0, 0, 0, 32'h0, chk, exp};
    endfunction

    // Word address in the low bits, lane index in the top conf bits.
    function automatic logic [ADDR_W-1:0] mkaddr(int conf, int lane, int word);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(word);
        if (conf > 0 && conf <= 5) a = a | ADDR_W'(lane << (ADDR_W - conf));
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_ports();
        csb_a = 1'b1; web_a = 1'b1; addr_a = '0; conf_a = 3'd0; wmode_a = 2'b10;
        out_reg_a = 1'b0; din_a = 32'h0;
        csb_b = 1'b1; web_b = 1'b1; addr_b = '0; conf_b = 3'd0; wmode_b = 2'b10;
        out_reg_b = 1'b0; din_b = 32'h0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && busy === 1'b1; i++) tick();
        chk("ready", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset(int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_ports();
        rst = 1'b0;

        // --- table: A ops, B ops, expected outputs after the edge ---
        vq.push_back('{wr(0,0,0,32'hAABBCCDD,2'b10,1,32'h0),        nop(0,1,32'h0)});
        vq.push_back('{wr(0,0,1,32'h01020304,2'b10,1,32'h0),        nop(0,0,32'h0)});
        vq.push_back('{rd(0,0,0,0,32'hAABBCCDD),                     nop(0,0,32'h0)});
        vq.push_back('{rd(0,0,1,1,32'hAABBCCDD),                     nop(0,0,32'h0)});
        vq.push_back('{nop(1,1,32'h01020304),                        nop(0,0,32'h0)});
        vq.push_back('{nop(0,1,32'h01020304),                        nop(0,0,32'h0)});
        vq.push_back('{wr(0,0,0,32'h0000FFAB,2'b10,1,32'h01020304),  nop(0,0,32'h0)});
        vq.push_back('{wr(5,31,0,32'hFFFFFFFF,2'b10,1,32'h01020304), nop(0,0,32'h0)});
        vq.push_back('{rd(0,0,0,0,32'h8000FFAB),                     nop(0,0,32'h0)});
        vq.push_back('{rd(5,31,0,0,32'h1),                           nop(0,0,32'h0)});
        vq.push_back('{rd(5,2,0,0,32'h0),                            nop(0,0,32'h0)});
        vq.push_back('{rd(5,0,0,0,32'h1),                            nop(0,0,32'h0)});
        vq.push_back('{wr(7,0,0,32'h0,2'b10,1,32'h0),                nop(0,0,32'h0)});
        vq.push_back('{rd(0,0,0,0,32'h8000FFAB),                     nop(0,0,32'h0)});
        vq.push_back('{rd(6,0,0,0,32'h0),                            nop(0,0,32'h0)});
        vq.push_back('{wr(0,0,2,32'h0000FFFF,2'b10,1,32'h0),         nop(0,0,32'h0)});
        vq.push_back('{wr(1,0,2,32'h1234,2'b00,1,32'h0000FFFF),      nop(0,0,32'h0)});
        vq.push_back('{wr(1,0,2,32'hFFFF,2'b01,1,32'h0000FFFF),      nop(0,0,32'h0)});
        vq.push_back('{wr(1,0,2,32'h1234,2'b01,1,32'h00001234),      nop(0,0,32'h0)});
        vq.push_back('{wr(1,0,2,32'hFFFF,2'b00,1,32'h00001234),      nop(0,0,32'h0)});
        vq.push_back('{wr(1,1,2,32'hABCD5555,2'b11,1,32'h00001234),  nop(0,0,32'h0)});
        vq.push_back('{rd(0,0,2,0,32'h5555FFFF),                     nop(0,0,32'h0)});
        vq.push_back('{wr(1,0,2,32'h1234,2'b10,1,32'h5555FFFF),      nop(0,0,32'h0)});
        vq.push_back('{rd(0,0,2,0,32'h55551234),                     nop(0,0,32'h0)});
        vq.push_back('{wr(0,0,7,32'h11223344,2'b10,1,32'h55551234),  wr(0,0,7,32'hAABBCCDD,2'b10,1,32'h0)});
        vq.push_back('{rd(0,0,7,0,32'h11223344),                     rd(0,0,7,0,32'h11223344)});
        vq.push_back('{wr(0,0,8,32'h0,2'b10,0,32'h0),                nop(0,0,32'h0)});
        vq.push_back('{wr(2,0,8,32'h11,2'b10,0,32'h0),               wr(2,3,8,32'h44,2'b10,0,32'h0)});
        vq.push_back('{rd(0,0,8,0,32'h44000011),                     rd(2,3,8,0,32'h44)});
        vq.push_back('{wr(1,0,8,32'hAAAA,2'b10,0,32'h0),             wr(0,0,8,32'h12345678,2'b01,1,32'h12345678)});
        vq.push_back('{rd(0,0,8,0,32'h1234AAAA),                     nop(0,1,32'h12345678)});
        vq.push_back('{wr(0,0,3,32'h9,2'b10,0,32'h0),                nop(0,0,32'h0)});
        vq.push_back('{wr(0,0,3,32'h5,2'b10,0,32'h0),                rd(0,0,3,0,32'h9)});
        vq.push_back('{wr(0,0,9,32'h0,2'b10,0,32'h0),                rd(0,0,3,0,32'h5)});
        vq.push_back('{nop(0,0,32'h0),                               wr(3,7,9,32'hA,2'b00,1,32'h0)});
        vq.push_back('{rd(0,0,9,0,32'hA0000000),                     wr(3,7,9,32'h3,2'b01,1,32'h3)});
        vq.push_back('{rd(0,0,9,0,32'h30000000),                     rd(4,14,9,0,32'h3)});

        // --- reset state ---
        do_reset(2);
        chk("rst_dout_a", dout_a, 32'h0);
        chk("rst_dout_b", dout_b, 32'h0);
        wait_ready();

        // --- table-driven vectors ---
        foreach (vq[i]) begin
            csb_a = !vq[i].a.en; web_a = !vq[i].a.wr; wmode_a = vq[i].a.wm;
            out_reg_a = vq[i].a.oreg; conf_a = 3'(vq[i].a.conf); din_a = vq[i].a.din;
            addr_a = mkaddr(vq[i].a.conf, vq[i].a.lane, vq[i].a.word);
            csb_b = !vq[i].b.en; web_b = !vq[i].b.wr; wmode_b = vq[i].b.wm;
            out_reg_b = vq[i].b.oreg; conf_b = 3'(vq[i].b.conf); din_b = vq[i].b.din;
            addr_b = mkaddr(vq[i].b.conf, vq[i].b.lane, vq[i].b.word);
            tick();
            if (vq[i].a.chk) chk($sformatf("vec%0d_a", i), dout_a, vq[i].a.exp);
            if (vq[i].b.chk) chk($sformatf("vec%0d_b", i), dout_b, vq[i].b.exp);
        end

        // --- reset clears both pipeline stages, array keeps its contents ---
        idle_ports();
        out_reg_a = 1'b1;
        do_reset(1);
        chk("rst2_dout_a_s2", dout_a, 32'h0);
        out_reg_a = 1'b0;
        chk("rst2_dout_a_s1", dout_a, 32'h0);
        chk("rst2_dout_b", dout_b, 32'h0);
        wait_ready();
        csb_a = 1'b0; addr_a = mkaddr(0, 0, 9);
        tick();
`ifdef FABRIC_BRAM_CLEAR_EN
        chk("post_rst_read", dout_a, 32'h0);
`else
        chk("post_rst_read", dout_a, 32'h30000000);
`endif

`ifdef FABRIC_BRAM_CLEAR_EN
        begin
            int cnt;
            int bad;
            // refill a few words, then sweep with a write attempted throughout
            idle_ports();
            csb_a = 1'b0; web_a = 1'b0; din_a = 32'h12345678;
            for (int w = 0; w < 4; w++) begin
                addr_a = mkaddr(0, 0, w);
                tick();
            end
            idle_ports();
            do_reset(2);
            chk("clr_busy_rst", {31'd0, busy}, 32'd1);
            csb_a = 1'b0; web_a = 1'b0; addr_a = mkaddr(0, 0, 5); din_a = 32'hDEADBEEF;
            cnt = 0; bad = 0;
            while (busy === 1'b1 && cnt < 100) begin
                cnt++;
                if (dout_a !== 32'h0) bad++;
                tick();
            end
            chk("clr_busy_len", 32'(cnt), 32'd16);
            chk("clr_dout_busy", 32'(bad), 32'd0);
            idle_ports();
            csb_a = 1'b0;
            for (int w = 0; w < TB_DEPTH; w++) begin
                addr_a = mkaddr(0, 0, w);
                tick();
                chk($sformatf("clr_word%0d", w), dout_a, 32'h0);
            end
            // reset in the middle of a sweep restarts it from word 0
            csb_a = 1'b0; web_a = 1'b0; addr_a = mkaddr(0, 0, 4); din_a = 32'hCAFE;
            tick();
            idle_ports();
            do_reset(1);
            for (int i = 0; i < 8; i++) tick();
            do_reset(1);
            cnt = 0;
            while (busy === 1'b1 && cnt < 100) begin
                cnt++;
                tick();
            end
            chk("clr_restart_len", 32'(cnt), 32'd16);
            csb_a = 1'b0; addr_a = mkaddr(0, 0, 4);
            tick();
            chk("clr_restart_word4", dout_a, 32'h0);
        end
`else
        chk("busy_tied", {31'd0, busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
